// File: rtl/rgb_color_scheduler_if.sv
// Pixel, configuration, mapper and RGB handshake signals for rgb_color_scheduler.
// The scheduler takes the master side; the surrounding environment takes the slave side.
interface rgb_color_scheduler_if;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_iter;
  logic        map_do_color;
  logic [15:0] map_data;
  logic [31:0] map_coeff;
  logic        map_done;
  logic [3:0]  map_value;
  logic        rgb_valid;
  logic        rgb_ready;
  logic [11:0] rgb_out;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  cfg_we, cfg_sel, cfg_data, pix_valid, pix_iter, map_done, map_value, rgb_ready,
    output pix_ready, map_do_color, map_data, map_coeff, rgb_valid, rgb_out, busy, timeout_err
  );

  modport slave (
    output cfg_we, cfg_sel, cfg_data, pix_valid, pix_iter, map_done, map_value, rgb_ready,
    input  pix_ready, map_do_color, map_data, map_coeff, rgb_valid, rgb_out, busy, timeout_err
  );
endinterface

// File: rtl/rgb_color_scheduler.sv
// Time-shares one colour mapper across the R, G and B coefficients and packs
// the three 4-bit results into a 12-bit VGA word; in-set pixels go straight to black.
module rgb_color_scheduler #(
  parameter logic [15:0] MAX_ITER_DEF = 16'd255,
  parameter logic [31:0] R_COEFF_DEF  = 32'h3DCCCCCD,
  parameter logic [31:0] G_COEFF_DEF  = 32'h3E4CCCCD,
  parameter logic [31:0] B_COEFF_DEF  = 32'h3E99999A,
  parameter int unsigned TIMEOUT      = 32'd255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rgb_color_scheduler_if.master bus
);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RELEASE   = 3'd3,
    S_OUTPUT    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0][3:0]  slot_q, slot_d;
  logic [2:0][31:0] coeff_q, coeff_d;
  logic [15:0]      max_iter_q, max_iter_d;
  logic [15:0]      map_data_q, map_data_d;
  logic [31:0]      map_coeff_q, map_coeff_d;
  logic [11:0]      rgb_out_q, rgb_out_d;
  logic             terr_q, terr_d;
  logic             accept_s, in_set_s, expired_s, last_ch_s;
  logic             pix_ready_s, busy_s, rgb_valid_s, do_color_s;

  function automatic logic [31:0] coeff_of(input logic [2:0][31:0] c, input logic [1:0] ch);
    logic [31:0] r;
    case (ch)
      2'd0:    r = c[0];
      2'd1:    r = c[1];
      2'd2:    r = c[2];
      default: r = c[0];
    endcase
    return r;
  endfunction

  assign accept_s  = bus.pix_valid && (state_q == S_IDLE);
  assign in_set_s  = (bus.pix_iter >= max_iter_q);
  assign expired_s = (cnt_q == TIMEOUT_LIM);
  assign last_ch_s = (ch_q == 2'd2);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = in_set_s ? S_OUTPUT : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE:     state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.map_done || expired_s) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_RELEASE: begin
        if (!bus.map_done || expired_s) begin
          state_d = last_ch_s ? S_OUTPUT : S_ISSUE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_OUTPUT: begin
        if (bus.rgb_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUTPUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    pix_ready_s = 1'b0;
    busy_s      = 1'b1;
    rgb_valid_s = 1'b0;
    do_color_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        pix_ready_s = 1'b1;
        busy_s      = 1'b0;
      end
      S_WAIT_DONE: do_color_s  = 1'b1;
      S_OUTPUT:    rgb_valid_s = 1'b1;
      default:     busy_s      = 1'b1;
    endcase
  end

  // Datapath next values: config registers, channel sequencing and result slots
  always_comb begin
    coeff_d     = coeff_q;
    max_iter_d  = max_iter_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    map_data_d  = map_data_q;
    map_coeff_d = map_coeff_q;
    rgb_out_d   = rgb_out_q;
    terr_d      = terr_q;
    if (bus.cfg_we) begin
      case (bus.cfg_sel)
        2'd0:    coeff_d[0] = bus.cfg_data;
        2'd1:    coeff_d[1] = bus.cfg_data;
        2'd2:    coeff_d[2] = bus.cfg_data;
        2'd3:    max_iter_d = bus.cfg_data[15:0];
        default: max_iter_d = max_iter_q;
      endcase
    end else begin
      coeff_d = coeff_q;
    end
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          map_data_d = bus.pix_iter;
          ch_d       = 2'd0;
          slot_d     = '0;
          rgb_out_d  = in_set_s ? 12'h000 : rgb_out_q;
        end else begin
          ch_d = ch_q;
        end
      end
      S_ISSUE: begin
        // Snapshot here so a config write cannot disturb an in-flight mapper pass
        map_coeff_d = coeff_of(coeff_q, ch_q);
        cnt_d       = 8'd0;
      end
      S_WAIT_DONE: begin
        if (bus.map_done) begin
          slot_d[ch_q] = bus.map_value;
          cnt_d        = 8'd0;
        end else if (expired_s) begin
          slot_d[ch_q] = 4'h0;
          terr_d       = 1'b1;
          cnt_d        = 8'd0;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      S_RELEASE: begin
        if (!bus.map_done || expired_s) begin
          terr_d = terr_q | (bus.map_done & expired_s);
          cnt_d  = 8'd0;
          if (last_ch_s) begin
            rgb_out_d = {slot_q[0], slot_q[1], slot_q[2]};
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      S_OUTPUT: rgb_out_d = rgb_out_q;
      default:  cnt_d     = 8'd0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coeff_q     <= {B_COEFF_DEF, G_COEFF_DEF, R_COEFF_DEF};
      max_iter_q  <= MAX_ITER_DEF;
      ch_q        <= 2'd0;
      cnt_q       <= 8'd0;
      slot_q      <= '0;
      map_data_q  <= 16'd0;
      map_coeff_q <= 32'd0;
      rgb_out_q   <= 12'h000;
      terr_q      <= 1'b0;
    end else begin
      coeff_q     <= coeff_d;
      max_iter_q  <= max_iter_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      map_data_q  <= map_data_d;
      map_coeff_q <= map_coeff_d;
      rgb_out_q   <= rgb_out_d;
      terr_q      <= terr_d;
    end
  end

  assign bus.pix_ready    = pix_ready_s;
  assign bus.busy         = busy_s;
  assign bus.rgb_valid    = rgb_valid_s;
  assign bus.map_do_color = do_color_s;
  assign bus.map_data     = map_data_q;
  assign bus.map_coeff    = map_coeff_q;
  assign bus.rgb_out      = rgb_out_q;
  assign bus.timeout_err  = terr_q;
endmodule
